// File: rtl/fc_mac_sequencer.sv
// Fully-connected neuron sequencer: streams N activation/weight pairs through a Q-format
// multiply, accumulates in a guard-extended register, adds bias, saturates and hands off.
module fc_mac_sequencer #(
  parameter int SIZE      = 16,
  parameter int PRECISION = 11,
  parameter int ADDR_W    = 8,
  parameter int GUARD     = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] num_inputs,
  input  logic [SIZE-1:0]   bias,
  output logic              busy,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [SIZE-1:0]   act_data,
  input  logic [SIZE-1:0]   wgt_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [SIZE-1:0]   result,
  output logic              sat
);

  localparam int ACC_W = SIZE + GUARD;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RUN   = 3'd1,
    DRAIN = 3'd2,
    BIAS  = 3'd3,
    OUT   = 3'd4
  } state_t;

  // Signed fixed-point multiply; keeps bits [PRECISION+SIZE-1:PRECISION] of the full product.
  function automatic logic [SIZE-1:0] fp_mul(input logic [SIZE-1:0] a, input logic [SIZE-1:0] b);
    logic signed [2*SIZE-1:0] a_x;
    logic signed [2*SIZE-1:0] b_x;
    logic signed [2*SIZE-1:0] prod_s;
    a_x    = {{SIZE{a[SIZE-1]}}, a};
    b_x    = {{SIZE{b[SIZE-1]}}, b};
    prod_s = a_x * b_x;
    return SIZE'(prod_s >>> PRECISION);
  endfunction

  function automatic logic [ACC_W-1:0] sext(input logic [SIZE-1:0] v);
    return {{GUARD{v[SIZE-1]}}, v};
  endfunction

  // Returns {sat, clamped word}; in range when all bits above the sign position agree.
  function automatic logic [SIZE:0] clamp(input logic [ACC_W-1:0] a);
    if (a[ACC_W-1:SIZE-1] == {(GUARD+1){a[ACC_W-1]}}) begin
      return {1'b0, a[SIZE-1:0]};
    end else if (a[ACC_W-1]) begin
      return {1'b1, 1'b1, {(SIZE-1){1'b0}}};
    end else begin
      return {1'b1, 1'b0, {(SIZE-1){1'b1}}};
    end
  endfunction

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] n_q, n_d;
  logic [SIZE-1:0]   bias_q, bias_d;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic [ADDR_W-1:0] index_q, index_d;
  logic              rd_en_q, rd_en_d;
  logic              pipe_valid_q;
  logic              busy_q, busy_d;
  logic              out_valid_q, out_valid_d;
  logic [SIZE-1:0]   result_q, result_d;
  logic              sat_q, sat_d;
  logic [ACC_W-1:0]  mac_sum_s;
  logic [ACC_W-1:0]  bias_sum_s;
  logic [SIZE:0]     clamp_s;

  assign mac_sum_s  = acc_q + sext(fp_mul(act_data, wgt_data));
  assign bias_sum_s = acc_q + sext(bias_q);
  assign clamp_s    = clamp(bias_sum_s);

  always_comb begin
    state_d     = state_q;
    n_d         = n_q;
    bias_d      = bias_q;
    acc_d       = acc_q;
    index_d     = index_q;
    out_valid_d = out_valid_q;
    result_d    = result_q;
    sat_d       = sat_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          n_d     = num_inputs;
          bias_d  = bias;
          acc_d   = '0;
          index_d = '0;
          if (num_inputs == '0) begin
            state_d = BIAS;
          end else begin
            state_d = RUN;
          end
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        // The read issued one cycle earlier returns its data now.
        if (pipe_valid_q) begin
          acc_d = mac_sum_s;
        end else begin
          acc_d = acc_q;
        end
        index_d = index_q + ADDR_W'(1);
        if (index_q == n_q - ADDR_W'(1)) begin
          state_d = DRAIN;
        end else begin
          state_d = RUN;
        end
      end
      DRAIN: begin
        if (pipe_valid_q) begin
          acc_d = mac_sum_s;
        end else begin
          acc_d = acc_q;
        end
        index_d = '0;
        state_d = BIAS;
      end
      BIAS: begin
        acc_d       = bias_sum_s;
        sat_d       = clamp_s[SIZE];
        result_d    = clamp_s[SIZE-1:0];
        out_valid_d = 1'b1;
        state_d     = OUT;
      end
      OUT: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end else begin
          state_d = OUT;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    rd_en_d = (state_d == RUN);
    busy_d  = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      n_q          <= '0;
      bias_q       <= '0;
      acc_q        <= '0;
      index_q      <= '0;
      rd_en_q      <= 1'b0;
      pipe_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      out_valid_q  <= 1'b0;
      result_q     <= '0;
      sat_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      n_q          <= n_d;
      bias_q       <= bias_d;
      acc_q        <= acc_d;
      index_q      <= index_d;
      rd_en_q      <= rd_en_d;
      pipe_valid_q <= rd_en_q;
      busy_q       <= busy_d;
      out_valid_q  <= out_valid_d;
      result_q     <= result_d;
      sat_q        <= sat_d;
    end
  end

  assign busy      = busy_q;
  assign rd_en     = rd_en_q;
  assign rd_addr   = index_q;
  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign sat       = sat_q;

endmodule

// File: tb/tb_fc_mac_sequencer.sv
// Scoreboard bench for fc_mac_sequencer: directed neurons push expected results; a negedge
// monitor models the buffers, checks read addresses, latency, result/sat and hold behaviour.
module tb_fc_mac_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  num_inputs;
  logic [15:0] bias;
  logic        busy;
  logic        rd_en;
  logic [7:0]  rd_addr;
  logic [15:0] act_data;
  logic [15:0] wgt_data;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] result;
  logic        sat;

  fc_mac_sequencer dut (
    .clk(clk), .rst(rst), .start(start), .num_inputs(num_inputs), .bias(bias),
    .busy(busy), .rd_en(rd_en), .rd_addr(rd_addr), .act_data(act_data),
    .wgt_data(wgt_data), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .sat(sat)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] res;
    logic        sat;
    int          vcyc;
    int          n;
  } exp_t;

  exp_t        sb[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  int          rd_cnt   = 0;
  logic [15:0] act_mem[256];
  logic [15:0] wgt_mem[256];
  logic        prev_en  = 1'b0;
  logic [7:0]  prev_addr = 8'd0;
  logic        ov_prev  = 1'b0;
  logic        hs_prev  = 1'b0;
  logic [15:0] hold_res = 16'd0;
  logic        hold_sat = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, got, want, cyc);
    end
  endtask

  // Buffer model plus output monitor, evaluated mid-cycle.
  always @(negedge clk) begin
    exp_t e;
    if (prev_en) begin
      act_data = act_mem[prev_addr];
      wgt_data = wgt_mem[prev_addr];
    end else begin
      act_data = 16'h5A5A;
      wgt_data = 16'hA5A5;
    end
    prev_en   = rd_en;
    prev_addr = rd_addr;
    if (!rst) begin
      if (rd_en) begin
        chk("rd_addr", 32'(rd_addr), 32'(rd_cnt));
        rd_cnt++;
      end
      if (hs_prev) begin
        chk("valid_drop", 32'(out_valid), 32'd0);
      end else if (out_valid && ov_prev) begin
        chk("hold_result", 32'(result), 32'(hold_res));
        chk("hold_sat", 32'(sat), 32'(hold_sat));
        chk("hold_busy", 32'(busy), 32'd1);
      end
      if (out_valid && !ov_prev) begin
        if (sb.size() == 0) begin
          chk("unexpected_valid", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          chk("result", 32'(result), 32'(e.res));
          chk("sat", 32'(sat), 32'(e.sat));
          chk("latency_cycle", 32'(cyc), 32'(e.vcyc));
          chk("read_count", 32'(rd_cnt), 32'(e.n));
        end
        hold_res = result;
        hold_sat = sat;
      end
    end
    ov_prev = out_valid;
    hs_prev = out_valid && out_ready;
  end

  task automatic fill(input int idx, input logic [15:0] a, input logic [15:0] w);
    act_mem[idx] = a;
    wgt_mem[idx] = w;
  endtask

  // Accept one neuron; expected out_valid cycle is t+N+3 (t+2 for N=0) relative to the start cycle.
  task automatic run(input int n, input logic [15:0] b, input logic [15:0] er, input logic es);
    exp_t e;
    num_inputs = n[7:0];
    bias       = b;
    start      = 1'b1;
    @(posedge clk); #1;
    start      = 1'b0;
    num_inputs = 8'hFF;
    bias       = 16'h7777;
    rd_cnt     = 0;
    e.res  = er;
    e.sat  = es;
    e.n    = n;
    e.vcyc = cyc + ((n == 0) ? 1 : n + 2);
    sb.push_back(e);
  endtask

  task automatic wait_idle(input int budget, input string name);
    logic done;
    done = 1'b0;
    for (int k = 0; k < budget && !done; k++) begin
      @(posedge clk); #1;
      done = !busy && (sb.size() == 0);
    end
    chk(name, 32'(done), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic seen;
    rst = 1'b1; start = 1'b0; num_inputs = 8'd0; bias = 16'd0; out_ready = 1'b1;
    act_data = 16'd0; wgt_data = 16'd0;
    for (int i = 0; i < 256; i++) fill(i, 16'd0, 16'd0);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_rd_en", 32'(rd_en), 32'd0);
    chk("rst_rd_addr", 32'(rd_addr), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_result", 32'(result), 32'd0);
    chk("rst_sat", 32'(sat), 32'd0);
    rst = 1'b0;

    // 0.5 + 0.5 - 0.5 + 0.25 = 0.75
    fill(0, 16'h0800, 16'h0400); fill(1, 16'h1000, 16'h0200); fill(2, 16'hFC00, 16'h0800);
    run(3, 16'h0200, 16'h0600, 1'b0);
    wait_idle(50, "n3_done");

    run(0, 16'hF800, 16'hF800, 1'b0);
    wait_idle(50, "n0_done");

    // 6.0*6.0 truncates to 0x2000 per product; four sum to 0x8000
    for (int i = 0; i < 4; i++) fill(i, 16'h3000, 16'h3000);
    run(4, 16'h0000, 16'h7FFF, 1'b1);
    wait_idle(50, "possat_done");

    // each product 0xE000; four sum to exactly -32768, which is representable
    for (int i = 0; i < 4; i++) fill(i, 16'hD000, 16'h3000);
    run(4, 16'h0000, 16'h8000, 1'b0);
    wait_idle(50, "negedge_done");
    run(4, 16'hFFFF, 16'h8000, 1'b1);
    wait_idle(50, "negsat_done");

    // back-pressure with start pulsed while holding
    fill(0, 16'h0800, 16'h0100); fill(1, 16'h0800, 16'h0100);
    out_ready = 1'b0;
    run(2, 16'h0000, 16'h0200, 1'b0);
    seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(posedge clk); #1;
      seen = out_valid;
    end
    chk("bp_valid_seen", 32'(seen), 32'd1);
    for (int k = 0; k < 5; k++) begin
      start      = (k == 2);
      num_inputs = 8'd5;
      @(posedge clk); #1;
      start = 1'b0;
      chk("bp_busy", 32'(busy), 32'd1);
    end
    out_ready  = 1'b1;
    start      = 1'b1;
    num_inputs = 8'd5;
    @(posedge clk); #1;
    start = 1'b0;
    chk("bp_idle_busy", 32'(busy), 32'd0);
    chk("bp_idle_valid", 32'(out_valid), 32'd0);
    wait_idle(10, "bp_done");

    fill(0, 16'h0800, 16'h0800);
    run(1, 16'hFF00, 16'h0700, 1'b0);
    wait_idle(50, "post_bp_done");

    // reset while reading address 2 of a 10-input neuron
    for (int i = 0; i < 10; i++) fill(i, 16'h0800, 16'h0800);
    run(10, 16'h0000, 16'h5000, 1'b0);
    void'(sb.pop_back());
    seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      seen = rd_en && (rd_addr == 8'd2);
      if (!seen) begin
        @(posedge clk); #1;
      end
    end
    chk("mid_idx2_seen", 32'(seen), 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("mid_busy", 32'(busy), 32'd0);
    chk("mid_rd_en", 32'(rd_en), 32'd0);
    chk("mid_rd_addr", 32'(rd_addr), 32'd0);
    chk("mid_out_valid", 32'(out_valid), 32'd0);
    chk("mid_result", 32'(result), 32'd0);
    chk("mid_sat", 32'(sat), 32'd0);
    rst = 1'b0;
    // 3.0 * -2.0 + 0.125 = -5.875
    fill(0, 16'h1800, 16'hF000);
    run(1, 16'h0100, 16'hD100, 1'b0);
    wait_idle(50, "after_rst_done");

    for (int i = 0; i < 255; i++) fill(i, 16'h0800, 16'h0008);
    run(255, 16'h0000, 16'h07F8, 1'b0);
    wait_idle(400, "n255_done");

    chk("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule
